// File: rtl/controlador_pkg.sv
// Shared definitions for the data-memory command controller.
// Macro COPIA_EN adds the copy states; without it, op 10 is rejected.
package controlador_pkg;

  localparam int LARGURA_END_PADRAO  = 4;
  localparam int LARGURA_DADO_PADRAO = 4;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPIA = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    LEITURA  = 3'd1,
    ESCRITA  = 3'd2,
`ifdef COPIA_EN
    COPIA_LE = 3'd3,
    COPIA_ES = 3'd4,
`endif
    FIM      = 3'd5
  } estado_t;

endpackage

// File: rtl/controlador_dados.sv
// Command controller driving a combinational-read data memory: load, store,
// fill and (with macro COPIA_EN) block copy. Without COPIA_EN op 10 ends in erro.
module controlador_dados
  import controlador_pkg::*;
#(
  parameter int LARGURA_END  = LARGURA_END_PADRAO,
  parameter int LARGURA_DADO = LARGURA_DADO_PADRAO
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic [1:0]              op,
  input  logic [LARGURA_END-1:0]  end_a,
  input  logic [LARGURA_END-1:0]  end_b,
  input  logic [LARGURA_END-1:0]  qtd,
  input  logic [LARGURA_DADO-1:0] dado_w,
  output logic [LARGURA_DADO-1:0] dado_r,
  output logic                    ocupado,
  output logic                    pronto,
  output logic                    erro,
  output logic [LARGURA_END-1:0]  mem_endereco,
  output logic                    mem_write,
  output logic                    mem_read,
  output logic [LARGURA_DADO-1:0] mem_dado_in,
  input  logic [LARGURA_DADO-1:0] mem_dado_out
);

  estado_t                 estado_q, estado_d;
  logic [1:0]              op_q, op_d;
  logic [LARGURA_END-1:0]  ptr_a_q, ptr_a_d;
  logic [LARGURA_END-1:0]  cnt_q, cnt_d;
  logic [LARGURA_DADO-1:0] dado_q, dado_d;
  logic [LARGURA_DADO-1:0] dado_r_q, dado_r_d;
`ifdef COPIA_EN
  logic [LARGURA_END-1:0]  ptr_b_q, ptr_b_d;
  logic [LARGURA_DADO-1:0] buf_q, buf_d;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      op_q     <= '0;
      ptr_a_q  <= '0;
      cnt_q    <= '0;
      dado_q   <= '0;
      dado_r_q <= '0;
`ifdef COPIA_EN
      ptr_b_q  <= '0;
      buf_q    <= '0;
`endif
    end else begin
      estado_q <= estado_d;
      op_q     <= op_d;
      ptr_a_q  <= ptr_a_d;
      cnt_q    <= cnt_d;
      dado_q   <= dado_d;
      dado_r_q <= dado_r_d;
`ifdef COPIA_EN
      ptr_b_q  <= ptr_b_d;
      buf_q    <= buf_d;
`endif
    end
  end

  // cnt holds the words still to move after the current one; a store is a fill of one word
  always_comb begin
    estado_d = estado_q;
    op_d     = op_q;
    ptr_a_d  = ptr_a_q;
    cnt_d    = cnt_q;
    dado_d   = dado_q;
    dado_r_d = dado_r_q;
`ifdef COPIA_EN
    ptr_b_d  = ptr_b_q;
    buf_d    = buf_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (req) begin
          op_d    = op;
          ptr_a_d = end_a;
          cnt_d   = (op == OP_STORE) ? '0 : qtd;
          dado_d  = dado_w;
`ifdef COPIA_EN
          ptr_b_d = end_b;
`endif
          case (op)
            OP_LOAD:  estado_d = LEITURA;
            OP_STORE: estado_d = ESCRITA;
            OP_FILL:  estado_d = ESCRITA;
`ifdef COPIA_EN
            default:  estado_d = COPIA_LE;
`else
            default:  estado_d = FIM;
`endif
          endcase
        end
      end
      LEITURA: begin
        dado_r_d = mem_dado_out;
        estado_d = FIM;
      end
      ESCRITA: begin
        ptr_a_d = ptr_a_q + 1'b1;
        if (cnt_q == '0) begin
          estado_d = FIM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef COPIA_EN
      COPIA_LE: begin
        buf_d    = mem_dado_out;
        estado_d = COPIA_ES;
      end
      COPIA_ES: begin
        ptr_a_d = ptr_a_q + 1'b1;
        ptr_b_d = ptr_b_q + 1'b1;
        if (cnt_q == '0) begin
          estado_d = FIM;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          estado_d = COPIA_LE;
        end
      end
`endif
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_endereco = '0;
    mem_dado_in  = '0;
    case (estado_q)
      LEITURA: begin
        mem_read     = 1'b1;
        mem_endereco = ptr_a_q;
      end
      ESCRITA: begin
        mem_write    = 1'b1;
        mem_endereco = ptr_a_q;
        mem_dado_in  = dado_q;
      end
`ifdef COPIA_EN
      COPIA_LE: begin
        mem_read     = 1'b1;
        mem_endereco = ptr_a_q;
      end
      COPIA_ES: begin
        mem_write    = 1'b1;
        mem_endereco = ptr_b_q;
        mem_dado_in  = buf_q;
      end
`endif
      default: ;
    endcase
  end

  assign ocupado = (estado_q != OCIOSO);
  assign pronto  = (estado_q == FIM);
  assign dado_r  = dado_r_q;

`ifdef COPIA_EN
  logic unused_op;
  assign unused_op = ^op_q;
  assign erro      = 1'b0;
`else
  logic unused_end_b;
  assign unused_end_b = ^end_b;
  assign erro         = pronto && (op_q == OP_COPIA);
`endif

endmodule
